// File: rtl/ram32_byte_loader_if.sv
// Host byte streams and RAM32 port for ram32_byte_loader.
// master: host/array side, slave: the loader.
interface ram32_byte_loader_if #(
  parameter int unsigned BANK_W = 6
);
  logic              cmd_valid;
  logic [7:0]        cmd_data;
  logic              cmd_ready;
  logic              rsp_valid;
  logic [7:0]        rsp_data;
  logic              rsp_ready;
  logic [BANK_W-1:0] mem_bank;
  logic [4:0]        mem_a;
  logic [31:0]       mem_d;
  logic              mem_we;
  logic [31:0]       mem_q;

  modport master (
    output cmd_valid, cmd_data, rsp_ready, mem_q,
    input  cmd_ready, rsp_valid, rsp_data, mem_bank, mem_a, mem_d, mem_we
  );

  modport slave (
    input  cmd_valid, cmd_data, rsp_ready, mem_q,
    output cmd_ready, rsp_valid, rsp_data, mem_bank, mem_a, mem_d, mem_we
  );
endinterface

// File: rtl/ram32_byte_loader.sv
// ram32_byte_loader: assembles host command bytes into 32-bit RAM32 writes
// and streams RAM32 words back to the host byte by byte, LSB first.
// Optional macro LOADER_AUTOINC_EN: frames carry len+1 words with the word
// address incrementing modulo 32 after each word; otherwise one word per frame.
module ram32_byte_loader #(
  parameter int unsigned NUM_BANKS = 64,
  parameter int unsigned BANK_W    = 6
) (
  input logic clk,
  input logic rst_n,
  input logic ena,
  ram32_byte_loader_if.slave bus
);
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned LEN_W  = 3;

  typedef enum logic [2:0] {
    H0, H1, WDATA, WRITE, RADDR, RWAIT, RDATA
  } state_t;

  state_t                   state;
  logic                     rw;
  logic                     bank_ok;
  logic [IDX_W-1:0]         idx;
  logic [WORD_W-BYTE_W-1:0] rdata;
  logic                     last_word;

`ifdef LOADER_AUTOINC_EN
  logic [LEN_W-1:0]         words_left;
  assign last_word = (words_left == LEN_W'(0));
`else
  assign last_word = 1'b1;
`endif

  // Command bytes are taken only in the header and write-data phases.
  assign bus.cmd_ready = rst_n & ena & ((state == H0) | (state == H1) | (state == WDATA));

  // Write strobe: one enabled cycle in WRITE, suppressed for banks beyond NUM_BANKS.
  assign bus.mem_we = ena & bank_ok & (state == WRITE);

  // Frame sequencer, byte assembly and read-back serialiser; frozen while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= H0;
      rw            <= 1'b0;
      bank_ok       <= 1'b0;
      idx           <= '0;
      rdata         <= '0;
      bus.mem_bank  <= '0;
      bus.mem_a     <= '0;
      bus.mem_d     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
`ifdef LOADER_AUTOINC_EN
      words_left    <= '0;
`endif
    end else if (ena) begin
      case (state)
        H0: if (bus.cmd_valid) begin
          rw           <= bus.cmd_data[7];
          bus.mem_bank <= BANK_W'(bus.cmd_data[5:0]);
          bank_ok      <= (32'(bus.cmd_data[5:0]) < NUM_BANKS);
          state        <= H1;
        end
        H1: if (bus.cmd_valid) begin
          bus.mem_a <= bus.cmd_data[ADDR_W-1:0];
`ifdef LOADER_AUTOINC_EN
          words_left <= bus.cmd_data[BYTE_W-1:ADDR_W];
`endif
          idx       <= '0;
          state     <= rw ? WDATA : RADDR;
        end
        WDATA: if (bus.cmd_valid) begin
          bus.mem_d <= {bus.cmd_data, bus.mem_d[WORD_W-1:BYTE_W]};
          idx       <= idx + IDX_W'(1);
          if (idx == IDX_W'(3)) state <= WRITE;
        end
        WRITE: begin
          idx <= '0;
          if (last_word) begin
            state <= H0;
          end else begin
            bus.mem_a <= bus.mem_a + ADDR_W'(1);
`ifdef LOADER_AUTOINC_EN
            words_left <= words_left - LEN_W'(1);
`endif
            state     <= WDATA;
          end
        end
        RADDR: state <= RWAIT;
        RWAIT: begin
          rdata         <= bank_ok ? bus.mem_q[WORD_W-1:BYTE_W] : '0;
          bus.rsp_data  <= bank_ok ? bus.mem_q[BYTE_W-1:0] : '0;
          bus.rsp_valid <= 1'b1;
          idx           <= '0;
          state         <= RDATA;
        end
        RDATA: if (bus.rsp_ready) begin
          if (idx == IDX_W'(3)) begin
            bus.rsp_valid <= 1'b0;
            idx           <= '0;
            if (last_word) begin
              state <= H0;
            end else begin
              bus.mem_a <= bus.mem_a + ADDR_W'(1);
`ifdef LOADER_AUTOINC_EN
              words_left <= words_left - LEN_W'(1);
`endif
              state     <= RADDR;
            end
          end else begin
            bus.rsp_data <= rdata[BYTE_W-1:0];
            rdata        <= rdata >> BYTE_W;
            idx          <= idx + IDX_W'(1);
          end
        end
        default: state <= H0;
      endcase
    end
  end
endmodule
